// File: rtl/prime_seq_checker_pkg.sv
// rtl/prime_seq_checker_pkg.sv - prime set table, FSM encoding and lock defaults
package prime_seq_checker_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam int DEF_LOCK_CNT   = 2;
  localparam int DEF_UNLOCK_CNT = 2;
  localparam int N_PRIMES       = 6;

  // Ascending order; entry i lives in bits [4*i +: 4].
  localparam logic [4*N_PRIMES-1:0] PRIME_TAB = {4'd13, 4'd11, 4'd7, 4'd5, 4'd3, 4'd2};

  function automatic logic [3:0] prime_at(input int idx);
    return PRIME_TAB[idx*4 +: 4];
  endfunction

endpackage

// File: rtl/prime_seq_checker_prime_step.sv
// rtl/prime_seq_checker_prime_step.sv - combinational prime-set membership and successor lookup
module prime_step
  import prime_seq_checker_pkg::*;
(
  input  logic [3:0] i_value,
  input  logic       i_dir,
  output logic       o_is_prime,
  output logic [3:0] o_successor
);

  always_comb begin
    o_is_prime  = 1'b0;
    o_successor = 4'd0;
    for (int i = 0; i < N_PRIMES; i++) begin
      if (i_value == prime_at(i)) begin
        o_is_prime  = 1'b1;
        o_successor = i_dir ? prime_at((i + N_PRIMES - 1) % N_PRIMES)
                            : prime_at((i + 1) % N_PRIMES);
      end
    end
  end

endmodule

// File: rtl/prime_seq_checker.sv
// rtl/prime_seq_checker.sv - lock/flywheel checker for a 4-bit prime-sequence counter
module prime_seq_checker
  import prime_seq_checker_pkg::*;
#(
  parameter int LOCK_CNT   = DEF_LOCK_CNT,
  parameter int UNLOCK_CNT = DEF_UNLOCK_CNT,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  input  logic             dir,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       expected,
  output logic             is_prime
);

  localparam int MW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
  localparam int XW = (UNLOCK_CNT > 1) ? $clog2(UNLOCK_CNT + 1) : 1;

  state_t           r_state, w_state_nxt;
  logic [MW-1:0]    r_match, w_match_nxt;
  logic [XW-1:0]    r_miss, w_miss_nxt;
  logic [3:0]       r_expected, w_expected_nxt;
  logic             r_err, w_err_nxt;
  logic [ERR_W-1:0] r_err_cnt, w_err_cnt_nxt;
  logic             r_is_prime, w_is_prime_nxt;
  logic             r_locked;

  logic             w_in_prime;
  logic [3:0]       w_in_succ;
  logic             w_exp_prime;
  logic [3:0]       w_exp_succ;
  logic [ERR_W-1:0] w_err_cnt_inc;

  prime_step u_step_in (
    .i_value     (in_data),
    .i_dir       (dir),
    .o_is_prime  (w_in_prime),
    .o_successor (w_in_succ)
  );

  // Flywheel path: advances the expectation when a locked sample is discarded.
  prime_step u_step_exp (
    .i_value     (r_expected),
    .i_dir       (dir),
    .o_is_prime  (w_exp_prime),
    .o_successor (w_exp_succ)
  );

  assign w_err_cnt_inc = (&r_err_cnt) ? r_err_cnt : r_err_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_HUNT;
      r_match    <= '0;
      r_miss     <= '0;
      r_expected <= 4'd0;
      r_err      <= 1'b0;
      r_err_cnt  <= '0;
      r_is_prime <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_match    <= w_match_nxt;
      r_miss     <= w_miss_nxt;
      r_expected <= w_expected_nxt;
      r_err      <= w_err_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
      r_is_prime <= w_is_prime_nxt;
      r_locked   <= (w_state_nxt == ST_LOCKED);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_match_nxt    = r_match;
    w_miss_nxt     = r_miss;
    w_expected_nxt = r_expected;
    w_err_nxt      = 1'b0;
    w_err_cnt_nxt  = r_err_cnt;
    w_is_prime_nxt = r_is_prime;

    if (in_valid) begin
      w_is_prime_nxt = w_in_prime;
      case (r_state)
        ST_HUNT: begin
          w_match_nxt = '0;
          w_miss_nxt  = '0;
          if (w_in_prime) begin
            w_state_nxt    = ST_SYNC;
            w_expected_nxt = w_in_succ;
          end else begin
            w_expected_nxt = 4'd0;
          end
        end
        ST_SYNC: begin
          if (in_data == r_expected) begin
            w_expected_nxt = w_in_succ;
            if (int'(r_match) + 1 >= LOCK_CNT) begin
              w_state_nxt = ST_LOCKED;
              w_match_nxt = '0;
              w_miss_nxt  = '0;
            end else begin
              w_match_nxt = r_match + 1'b1;
            end
          end else if (w_in_prime) begin
            w_match_nxt    = '0;
            w_expected_nxt = w_in_succ;
          end else begin
            w_state_nxt    = ST_HUNT;
            w_match_nxt    = '0;
            w_expected_nxt = 4'd0;
          end
        end
        ST_LOCKED: begin
          if (in_data == r_expected) begin
            w_miss_nxt     = '0;
            w_expected_nxt = w_in_succ;
          end else begin
            w_err_nxt     = 1'b1;
            w_err_cnt_nxt = w_err_cnt_inc;
            // A non-prime expectation cannot flywheel, so treat it as lost lock.
            if ((int'(r_miss) + 1 >= UNLOCK_CNT) || !w_exp_prime) begin
              w_state_nxt    = ST_HUNT;
              w_miss_nxt     = '0;
              w_expected_nxt = 4'd0;
            end else begin
              w_miss_nxt     = r_miss + 1'b1;
              w_expected_nxt = w_exp_succ;
            end
          end
        end
        default: begin
          w_state_nxt    = ST_HUNT;
          w_match_nxt    = '0;
          w_miss_nxt     = '0;
          w_expected_nxt = 4'd0;
        end
      endcase
    end
  end

  assign locked   = r_locked;
  assign err      = r_err;
  assign err_cnt  = r_err_cnt;
  assign expected = r_expected;
  assign is_prime = r_is_prime;

endmodule
